// File: rtl/adc_mv_bcd.sv
// ---------------------------------------------------------------------------
// adc_mv_bcd
//
// Purpose:
//   Converts raw ADC codes into four BCD millivolt digits for the four-digit
//   seven-segment driver. Each accepted sample is scaled to mV, turned into
//   BCD by a sequential double-dabble, and held on the display for a
//   minimum time so the digits stay readable.
//
// Ports:
//   clk           in   system clock (48 MHz)
//   rst           in   synchronous, active-high reset
//   sample_valid  in   one-cycle strobe, sample is valid this cycle
//   sample        in   raw ADC code, DATA_W bits
//   num1..num4    out  ones / tens / hundreds / thousands digit
//   upd           out  one-cycle pulse when num1..num4 change
//   busy          out  high in every state except IDLE
//
// Build option:
//   ADC_MV_BCD_LEADING_ZERO_BLANK_EN  when defined, leading-zero digits
//   (num4 downward, never num1) are shown as BLANK_CODE.
//
// State table:
//   state  | meaning
//   IDLE   | waiting for a new sample or a pending one
//   MULT   | scale the accepted sample to mV, clear the BCD register
//   CONV   | 14 double-dabble steps, one mV bit per cycle
//   DONE   | publish digits, pulse upd, load the hold timer
//   HOLD   | display hold, counts down to 1 then returns to IDLE
// ---------------------------------------------------------------------------
module adc_mv_bcd #(
   parameter int unsigned DATA_W      = 8,
   parameter int unsigned VREF_MV     = 5000,
   parameter int unsigned HOLD_CYCLES = 4800000,
   parameter logic [3:0]  BLANK_CODE  = 4'hF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sample_valid,
   input  logic [DATA_W-1:0] sample,
   output logic [3:0]        num1,
   output logic [3:0]        num2,
   output logic [3:0]        num3,
   output logic [3:0]        num4,
   output logic              upd,
   output logic              busy
);

   localparam int unsigned PROD_W = DATA_W + 14;
   localparam int unsigned HOLD_W = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
   localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES);
   localparam logic [13:0]       VREF      = 14'(VREF_MV);

   typedef enum logic [2:0] {
      S_IDLE,
      S_MULT,
      S_CONV,
      S_DONE,
      S_HOLD
   } state_t;

   state_t              state_q;
   logic [DATA_W-1:0]   smp_q;
   logic                pend_q;
   logic [DATA_W-1:0]   pend_smp_q;
   logic [13:0]         mv_q;
   logic [15:0]         bcd_q;
   logic [3:0]          bit_cnt_q;
   logic [HOLD_W-1:0]   hold_q;

   logic [PROD_W-1:0]   prod_d;
   logic [13:0]         mv_d;
   logic [15:0]         adj_d;
   logic [15:0]         bcd_d;
   logic [3:0]          dig1_d;
   logic [3:0]          dig2_d;
   logic [3:0]          dig3_d;
   logic [3:0]          dig4_d;

   // Truncating scale: mv = floor(sample * VREF / 2^DATA_W).
   always_comb begin
      prod_d = PROD_W'(smp_q) * PROD_W'(VREF);
      mv_d   = 14'(prod_d >> DATA_W);
   end

   // One double-dabble step: correct nibbles >= 5, then shift in the mV MSB.
   always_comb begin
      adj_d = bcd_q;
      for (int i = 0; i < 4; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5) begin
            adj_d[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
         end
      end
      bcd_d = (adj_d << 1) | {15'd0, mv_q[13]};
   end

   always_comb begin
      dig1_d = bcd_q[3:0];
      dig2_d = bcd_q[7:4];
      dig3_d = bcd_q[11:8];
      dig4_d = bcd_q[15:12];
`ifdef ADC_MV_BCD_LEADING_ZERO_BLANK_EN
      // Blanking ripples down from the thousands digit and stops at the
      // first non-zero digit; the ones digit always stays lit.
      if (bcd_q[15:12] == 4'd0) begin
         dig4_d = BLANK_CODE;
         if (bcd_q[11:8] == 4'd0) begin
            dig3_d = BLANK_CODE;
            if (bcd_q[7:4] == 4'd0) begin
               dig2_d = BLANK_CODE;
            end
         end
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         smp_q      <= '0;
         pend_q     <= 1'b0;
         pend_smp_q <= '0;
         mv_q       <= '0;
         bcd_q      <= '0;
         bit_cnt_q  <= '0;
         hold_q     <= '0;
         num1       <= 4'd0;
         num2       <= 4'd0;
         num3       <= 4'd0;
         num4       <= 4'd0;
         upd        <= 1'b0;
         busy       <= 1'b0;
      end else begin
         upd <= 1'b0;

         // Samples arriving while busy are parked; the newest one wins.
         if (sample_valid && (state_q != S_IDLE)) begin
            pend_q     <= 1'b1;
            pend_smp_q <= sample;
         end

         unique case (state_q)
            S_IDLE: begin
               if (sample_valid) begin
                  smp_q   <= sample;
                  pend_q  <= 1'b0;
                  state_q <= S_MULT;
                  busy    <= 1'b1;
               end else if (pend_q) begin
                  smp_q   <= pend_smp_q;
                  pend_q  <= 1'b0;
                  state_q <= S_MULT;
                  busy    <= 1'b1;
               end else begin
                  busy    <= 1'b0;
               end
            end

            S_MULT: begin
               mv_q      <= mv_d;
               bcd_q     <= '0;
               bit_cnt_q <= 4'd14;
               state_q   <= S_CONV;
               busy      <= 1'b1;
            end

            S_CONV: begin
               bcd_q     <= bcd_d;
               mv_q      <= {mv_q[12:0], 1'b0};
               bit_cnt_q <= bit_cnt_q - 4'd1;
               if (bit_cnt_q == 4'd1) begin
                  state_q <= S_DONE;
               end
               busy      <= 1'b1;
            end

            S_DONE: begin
               num1   <= dig1_d;
               num2   <= dig2_d;
               num3   <= dig3_d;
               num4   <= dig4_d;
               upd    <= 1'b1;
               hold_q <= HOLD_LOAD;
               if (HOLD_CYCLES == 0) begin
                  state_q <= S_IDLE;
                  busy    <= 1'b0;
               end else begin
                  state_q <= S_HOLD;
                  busy    <= 1'b1;
               end
            end

            S_HOLD: begin
               hold_q <= hold_q - HOLD_W'(1);
               if (hold_q <= HOLD_W'(1)) begin
                  state_q <= S_IDLE;
                  busy    <= 1'b0;
               end else begin
                  busy    <= 1'b1;
               end
            end

            default: begin
               state_q <= S_IDLE;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_adc_mv_bcd.sv
module tb_adc_mv_bcd;

   localparam int HOLD = 4;
   localparam int LAT  = 16;

   logic       clk = 1'b0;
   logic       rst;
   logic       sample_valid;
   logic [7:0] sample;
   logic [3:0] num1, num2, num3, num4;
   logic       upd, busy;

   adc_mv_bcd #(
      .DATA_W      (8),
      .VREF_MV     (5000),
      .HOLD_CYCLES (HOLD),
      .BLANK_CODE  (4'hF)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .sample_valid (sample_valid),
      .sample       (sample),
      .num1         (num1),
      .num2         (num2),
      .num3         (num3),
      .num4         (num4),
      .upd          (upd),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   typedef struct {
      logic [15:0] digits;
      int          exp_cyc;
      int          exp_gap;
   } exp_t;

   exp_t sb[$];
   int checks   = 0;
   int failures = 0;
   int n_upd    = 0;
   int n_exp    = 0;
   int last_upd = -1000;

   // Reference: display digits from the scaling and decimal rules.
   function automatic logic [15:0] model(input int s);
      int mv, d4, d3, d2, d1;
      mv = (s * 5000) / 256;
      d4 = mv / 1000;
      d3 = (mv / 100) % 10;
      d2 = (mv / 10) % 10;
      d1 = mv % 10;
`ifdef ADC_MV_BCD_LEADING_ZERO_BLANK_EN
      if (d4 == 0) begin
         d4 = 15;
         if (d3 == 0) begin
            d3 = 15;
            if (d2 == 0) d2 = 15;
         end
      end
`endif
      return {d4[3:0], d3[3:0], d2[3:0], d1[3:0]};
   endfunction

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Monitor: compares every upd pulse against the scoreboard head.
   always @(negedge clk) begin
      if (rst === 1'b0 && upd === 1'b1) begin
         exp_t e;
         n_upd++;
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_upd actual=%0h%0h%0h%0h required=none cyc=%0d",
                     num4, num3, num2, num1, cyc);
         end else begin
            e = sb.pop_front();
            check("digits", int'({num4, num3, num2, num1}), int'(e.digits));
            if (e.exp_cyc >= 0) check("latency", cyc, e.exp_cyc);
            if (e.exp_gap >= 0) check("upd_gap", cyc - last_upd, e.exp_gap);
         end
         last_upd = cyc;
      end
   end

   task automatic push_exp(input logic [7:0] s, input int ecyc, input int egap);
      exp_t e;
      e.digits  = model(int'(s));
      e.exp_cyc = ecyc;
      e.exp_gap = egap;
      sb.push_back(e);
      n_exp++;
   endtask

   // Returns at a negedge with the DUT idle and no outstanding expectation.
   task automatic wait_idle();
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (busy === 1'b0 && sb.size() == 0) return;
      end
      checks++;
      failures++;
      $display("FAIL wait_idle_timeout actual=busy%0b/q%0d required=idle", busy, sb.size());
   endtask

   task automatic send_idle(input logic [7:0] s);
      wait_idle();
      sample_valid = 1'b1;
      sample       = s;
      push_exp(s, cyc + 1 + LAT, -1);
      @(negedge clk);
      sample_valid = 1'b0;
      check("busy_after_accept", int'(busy), 1);
   endtask

   task automatic pulse(input logic [7:0] s);
      sample_valid = 1'b1;
      sample       = s;
      @(negedge clk);
      sample_valid = 1'b0;
   endtask

   initial begin
      int cnt;
      logic [7:0] last;
      int n;
      rst          = 1'b1;
      sample_valid = 1'b0;
      sample       = 8'h00;
      repeat (3) @(negedge clk);
      check("rst_digits", int'({num4, num3, num2, num1}), 0);
      check("rst_upd", int'(upd), 0);
      check("rst_busy", int'(busy), 0);
      rst = 1'b0;

      // 0x80 -> 2500, busy for MULT + 14 CONV + DONE + HOLD cycles
      send_idle(8'h80);
      cnt = 1;
      for (int i = 0; i < 100 && busy === 1'b1; i++) begin
         @(negedge clk);
         if (busy === 1'b1) cnt++;
      end
      check("busy_len", cnt, LAT + HOLD);

      send_idle(8'hFF);
      send_idle(8'h00);

      // Two samples during CONV: only the newest is converted, right after hold.
      send_idle(8'h40);
      repeat (3) @(negedge clk);
      pulse(8'h10);
      @(negedge clk);
      pulse(8'h20);
      push_exp(8'h20, -1, HOLD + 1 + LAT);

      // Fresh sample in the IDLE cycle overrides a parked one.
      send_idle(8'h33);
      repeat (2) @(negedge clk);
      pulse(8'h10);
      for (int i = 0; i < 100 && busy !== 1'b0; i++) @(negedge clk);
      check("idle_before_override", int'(busy), 0);
      sample_valid = 1'b1;
      sample       = 8'h30;
      push_exp(8'h30, cyc + 1 + LAT, -1);
      @(negedge clk);
      sample_valid = 1'b0;
      wait_idle();
      repeat (30) @(negedge clk);

      // Reset during CONV discards the conversion entirely.
      pulse(8'hFF);
      repeat (5) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("midrst_digits", int'({num4, num3, num2, num1}), 0);
      check("midrst_busy", int'(busy), 0);
      check("midrst_upd", int'(upd), 0);
      rst = 1'b0;
      repeat (30) @(negedge clk);
      send_idle(8'h01);

      for (int s = 0; s < 256; s++) send_idle(8'(s));

      // Random bursts: one accepted sample plus 0..3 overlapping ones.
      for (int b = 0; b < 40; b++) begin
         send_idle(8'($urandom_range(0, 255)));
         n = $urandom_range(0, 3);
         last = 8'h00;
         for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            last = 8'($urandom_range(0, 255));
            pulse(last);
         end
         if (n > 0) push_exp(last, -1, HOLD + 1 + LAT);
      end

      wait_idle();
      repeat (40) @(negedge clk);
      check("queue_drained", sb.size(), 0);
      check("upd_count", n_upd, n_exp);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
